// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags.
// Commits and renames come from the ROB. Operand queries are combinational and forward ROB results.
module reg_file_rename #(
  parameter int unsigned ROB_WIDTH_BIT = 5
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear_flag,
  input  logic [4:0]               commit_reg_id,
  input  logic [31:0]              commit_val,
  input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
  input  logic [4:0]               new_reg_id,
  input  logic [ROB_WIDTH_BIT-1:0] new_rob_id,
  input  logic [4:0]               dec_rs1_addr,
  input  logic [4:0]               dec_rs2_addr,
  output logic [ROB_WIDTH_BIT-1:0] rob_rs1_id,
  input  logic                     rob_rs1_ready,
  input  logic [31:0]              rob_rs1_val,
  output logic [ROB_WIDTH_BIT-1:0] rob_rs2_id,
  input  logic                     rob_rs2_ready,
  input  logic [31:0]              rob_rs2_val,
  output logic                     rs1_ready,
  output logic [31:0]              rs1_val,
  output logic [ROB_WIDTH_BIT-1:0] rs1_tag,
  output logic                     rs2_ready,
  output logic [31:0]              rs2_val,
  output logic [ROB_WIDTH_BIT-1:0] rs2_tag
);

  typedef struct packed {
    logic                     ready;
    logic [31:0]              val;
    logic [ROB_WIDTH_BIT-1:0] tag;
  } query_t;

  logic [31:0]              r_val [32];
  logic [ROB_WIDTH_BIT-1:0] r_tag [32];
  logic [31:0]              r_busy;

  logic   w_commit_en;
  logic   w_rename_en;
  logic   w_commit_clr;
  logic   w_bypass_ok;
  query_t w_q1;
  query_t w_q2;

  assign w_commit_en = (commit_reg_id != 5'd0);
  assign w_rename_en = (new_reg_id != 5'd0);
  // A stale tag, or a same-cycle rename of the same rd, must leave the register busy.
  assign w_commit_clr = w_commit_en && (r_tag[commit_reg_id] == commit_rob_id) &&
                        (commit_reg_id != new_reg_id);
  assign w_bypass_ok = w_commit_en && !clear_flag && rdy_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
      r_busy <= '0;
    end else if (rdy_in) begin
      if (clear_flag) begin
        for (int i = 0; i < 32; i++) begin
          r_tag[i] <= '0;
        end
        r_busy <= '0;
      end else begin
        if (w_commit_en) begin
          r_val[commit_reg_id] <= commit_val;
          if (w_commit_clr) begin
            r_busy[commit_reg_id] <= 1'b0;
          end
        end
        if (w_rename_en) begin
          r_busy[new_reg_id] <= 1'b1;
          r_tag[new_reg_id]  <= new_rob_id;
        end
      end
    end
  end

  function automatic query_t lookup(
    input logic [4:0]               addr,
    input logic                     busy,
    input logic [ROB_WIDTH_BIT-1:0] tag,
    input logic [31:0]              val,
    input logic                     fwd_ready,
    input logic [31:0]              fwd_val
  );
    query_t q;
    q = '0;
    if (addr == 5'd0 || !busy) begin
      q.ready = 1'b1;
      q.val   = (addr == 5'd0) ? 32'd0 : val;
    end else if (w_bypass_ok && commit_reg_id == addr && commit_rob_id == tag) begin
      q.ready = 1'b1;
      q.val   = commit_val;
    end else if (fwd_ready) begin
      q.ready = 1'b1;
      q.val   = fwd_val;
    end else begin
      q.tag = tag;
    end
    return q;
  endfunction

  always_comb begin
    w_q1 = lookup(dec_rs1_addr, r_busy[dec_rs1_addr], r_tag[dec_rs1_addr],
                  r_val[dec_rs1_addr], rob_rs1_ready, rob_rs1_val);
    w_q2 = lookup(dec_rs2_addr, r_busy[dec_rs2_addr], r_tag[dec_rs2_addr],
                  r_val[dec_rs2_addr], rob_rs2_ready, rob_rs2_val);
  end

  assign rob_rs1_id = r_busy[dec_rs1_addr] ? r_tag[dec_rs1_addr] : '0;
  assign rob_rs2_id = r_busy[dec_rs2_addr] ? r_tag[dec_rs2_addr] : '0;

  assign rs1_ready = w_q1.ready;
  assign rs1_val   = w_q1.val;
  assign rs1_tag   = w_q1.tag;
  assign rs2_ready = w_q2.ready;
  assign rs2_val   = w_q2.val;
  assign rs2_tag   = w_q2.tag;

endmodule

// File: tb/tb_reg_file_rename.sv
// Scoreboard bench for reg_file_rename: directed scenarios then random traffic against a
// behavioural register/rename model.
module tb_reg_file_rename;

  localparam int W = 5;

  logic         clk_in = 1'b0;
  logic         rst_in, rdy_in, clear_flag;
  logic [4:0]   commit_reg_id, new_reg_id, dec_rs1_addr, dec_rs2_addr;
  logic [31:0]  commit_val, rob_rs1_val, rob_rs2_val;
  logic [W-1:0] commit_rob_id, new_rob_id, rob_rs1_id, rob_rs2_id;
  logic         rob_rs1_ready, rob_rs2_ready;
  logic         rs1_ready, rs2_ready;
  logic [31:0]  rs1_val, rs2_val;
  logic [W-1:0] rs1_tag, rs2_tag;

  reg_file_rename #(.ROB_WIDTH_BIT(W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
    .commit_reg_id(commit_reg_id), .commit_val(commit_val), .commit_rob_id(commit_rob_id),
    .new_reg_id(new_reg_id), .new_rob_id(new_rob_id),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
    .rob_rs1_id(rob_rs1_id), .rob_rs1_ready(rob_rs1_ready), .rob_rs1_val(rob_rs1_val),
    .rob_rs2_id(rob_rs2_id), .rob_rs2_ready(rob_rs2_ready), .rob_rs2_val(rob_rs2_val),
    .rs1_ready(rs1_ready), .rs1_val(rs1_val), .rs1_tag(rs1_tag),
    .rs2_ready(rs2_ready), .rs2_val(rs2_val), .rs2_tag(rs2_tag)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic         rdy1, rdy2;
    logic [31:0]  val1, val2;
    logic [W-1:0] tag1, tag2, rob1, rob2;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_val [32];
  logic        m_busy [32];
  logic [W-1:0] m_tag [32];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
    end
  endtask

  // Register file semantics applied once per clock edge with the inputs that were held.
  task automatic model_update();
    if (rst_in) model_reset();
    else if (!rdy_in) begin
    end else if (clear_flag) begin
      for (int i = 0; i < 32; i++) begin
        m_busy[i] = 0; m_tag[i] = 0;
      end
    end else begin
      if (commit_reg_id != 0) begin
        m_val[commit_reg_id] = commit_val;
        if (m_tag[commit_reg_id] == commit_rob_id && commit_reg_id != new_reg_id)
          m_busy[commit_reg_id] = 0;
      end
      if (new_reg_id != 0) begin
        m_busy[new_reg_id] = 1; m_tag[new_reg_id] = new_rob_id;
      end
    end
  endtask

  task automatic model_query(input logic [4:0] a, input logic fr, input logic [31:0] fv,
                             output logic rdy, output logic [31:0] v, output logic [W-1:0] t,
                             output logic [W-1:0] rid);
    rid = m_busy[a] ? m_tag[a] : '0;
    rdy = 1; v = 0; t = 0;
    if (a == 0 || !m_busy[a]) v = m_val[a];
    else if (commit_reg_id == a && commit_rob_id == m_tag[a] && !clear_flag && rdy_in)
      v = commit_val;
    else if (fr) v = fv;
    else begin
      rdy = 0; t = m_tag[a];
    end
  endtask

  // Inputs are already set; push expectation, clock the DUT, then advance the model.
  task automatic cycle(input bit chk);
    exp_t e;
    if (chk) begin
      model_query(dec_rs1_addr, rob_rs1_ready, rob_rs1_val, e.rdy1, e.val1, e.tag1, e.rob1);
      model_query(dec_rs2_addr, rob_rs2_ready, rob_rs2_val, e.rdy2, e.val2, e.tag2, e.rob2);
      sb.push_back(e);
    end
    @(posedge clk_in);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst_in = 0; rdy_in = 1; clear_flag = 0;
    commit_reg_id = 0; commit_val = 0; commit_rob_id = 0;
    new_reg_id = 0; new_rob_id = 0;
    rob_rs1_ready = 0; rob_rs1_val = 0; rob_rs2_ready = 0; rob_rs2_val = 0;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk_in) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      cmp("rs1_ready", 32'(rs1_ready), 32'(e.rdy1));
      cmp("rs1_val", rs1_val, e.val1);
      cmp("rs1_tag", 32'(rs1_tag), 32'(e.tag1));
      cmp("rob_rs1_id", 32'(rob_rs1_id), 32'(e.rob1));
      cmp("rs2_ready", 32'(rs2_ready), 32'(e.rdy2));
      cmp("rs2_val", rs2_val, e.val2);
      cmp("rs2_tag", 32'(rs2_tag), 32'(e.tag2));
      cmp("rob_rs2_id", 32'(rob_rs2_id), 32'(e.rob2));
    end
  end

  initial begin
    idle();
    dec_rs1_addr = 5; dec_rs2_addr = 0;
    rst_in = 1;
    model_reset();
    @(posedge clk_in); #1;
    cycle(0); cycle(0);
    rst_in = 0;
    cycle(1);                                              // reset state of x5
    // Rename then ROB forward.
    new_reg_id = 3; new_rob_id = 7; cycle(1);
    idle(); dec_rs1_addr = 3; dec_rs2_addr = 3; cycle(1);
    rob_rs1_ready = 1; rob_rs1_val = 32'h55; cycle(1);
    // Commit bypass, then settled value.
    idle(); commit_reg_id = 3; commit_rob_id = 7; commit_val = 32'hAB; cycle(1);
    idle(); cycle(1);
    // Stale-tag commit.
    new_reg_id = 3; new_rob_id = 7; cycle(1);
    new_reg_id = 3; new_rob_id = 9; cycle(1);
    idle(); commit_reg_id = 3; commit_rob_id = 7; commit_val = 32'h11; cycle(1);
    idle(); cycle(1);
    commit_reg_id = 3; commit_rob_id = 9; commit_val = 32'h22; cycle(1);
    idle(); cycle(1);
    // Commit and rename on the same register in one cycle.
    new_reg_id = 4; new_rob_id = 2; cycle(1);
    idle(); dec_rs1_addr = 4; commit_reg_id = 4; commit_rob_id = 2; commit_val = 32'h44;
    new_reg_id = 4; new_rob_id = 6; cycle(1);
    idle(); cycle(1);
    // Flush with a simultaneous commit, pause, then x0.
    new_reg_id = 1; new_rob_id = 3; cycle(1);
    new_reg_id = 2; new_rob_id = 4; cycle(1);
    idle(); dec_rs1_addr = 1; dec_rs2_addr = 2;
    clear_flag = 1; commit_reg_id = 1; commit_rob_id = 3; commit_val = 32'hDEAD; cycle(1);
    idle(); cycle(1);
    new_reg_id = 2; new_rob_id = 5; cycle(1);
    idle(); rdy_in = 0; commit_reg_id = 2; commit_rob_id = 5; commit_val = 32'hBEEF;
    new_reg_id = 1; new_rob_id = 8; cycle(1);
    idle(); cycle(1);
    new_reg_id = 0; commit_reg_id = 0; commit_val = 32'h99; dec_rs1_addr = 0; cycle(1);
    idle(); cycle(1);
    // Random traffic on a narrow register range so collisions are frequent.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] cr;
      rst_in     = ($urandom_range(0, 199) == 0);
      rdy_in     = ($urandom_range(0, 9) != 0);
      clear_flag = ($urandom_range(0, 29) == 0);
      cr = 5'($urandom_range(0, 7));
      commit_reg_id = cr;
      commit_val    = $urandom;
      commit_rob_id = ($urandom_range(0, 1) == 0) ? m_tag[cr] : W'($urandom);
      new_reg_id    = 5'($urandom_range(0, 7));
      new_rob_id    = W'($urandom);
      dec_rs1_addr  = ($urandom_range(0, 2) == 0) ? cr : 5'($urandom_range(0, 7));
      dec_rs2_addr  = 5'($urandom_range(0, 7));
      rob_rs1_ready = $urandom_range(0, 1) == 1;
      rob_rs1_val   = $urandom;
      rob_rs2_ready = $urandom_range(0, 1) == 1;
      rob_rs2_val   = $urandom;
      cycle(1);
    end
    idle();
    @(negedge clk_in);
    @(negedge clk_in);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Architectural register file with per-register rename tags for the Tomasulo core. It sits between the decoder and the reorder buffer.
- Receives commit writes and new-tail rename notifications from the ROB.
- Answers decoder operand queries, forwarding ROB-held results when a register is still renamed.
- Drops all renames on a ROB flush.

Parameters:
- ROB_WIDTH_BIT, 5, width of a ROB tag; ROB depth is 2^ROB_WIDTH_BIT.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset
- rdy_in  input  1  pause: state is frozen when low
- clear_flag  input  1  ROB mispredict flush
- commit_reg_id  input  5  committed rd; 0 = no commit
- commit_val  input  32  committed value
- commit_rob_id  input  ROB_WIDTH_BIT  ROB tag of the committing entry
- new_reg_id  input  5  rd of the instruction entering ROB this cycle; 0 = none
- new_rob_id  input  ROB_WIDTH_BIT  ROB tag assigned to it
- dec_rs1_addr  input  5  decoder source 1 index
- dec_rs2_addr  input  5  decoder source 2 index
- rob_rs1_id  output  ROB_WIDTH_BIT  tag forwarded to ROB dependency query
- rob_rs1_ready  input  1  ROB reports rob_rs1_id result available
- rob_rs1_val  input  32  ROB result for rob_rs1_id
- rob_rs2_id, rob_rs2_ready, rob_rs2_val: same as rs1, for source 2
- rs1_ready  output  1  operand 1 value valid
- rs1_val  output  32  operand 1 value (0 when not ready)
- rs1_tag  output  ROB_WIDTH_BIT  producing ROB tag (0 when ready)
- rs2_ready, rs2_val, rs2_tag: same as rs1, for source 2

Behaviour:
- Clock and reset: single clock clk_in. rst_in is synchronous and active-high. Reset sets all 32 values to 0, all busy bits to 0, and all tags to 0.
- State per register i: val[i] (32 bits), busy[i], tag[i] (ROB_WIDTH_BIT bits).
  - x0 is hardwired: val 0, never busy. Writes and renames to index 0 are ignored.
- Update priority, evaluated on each posedge:
  - rst_in
  - then !rdy_in: hold all state
  - then clear_flag: all busy cleared, tags cleared, values kept; commit and rename inputs ignored this cycle
  - else normal update
- Normal update, commit (commit_reg_id != 0):
  - val[commit_reg_id] <= commit_val.
  - busy is cleared only if tag[commit_reg_id] == commit_rob_id and commit_reg_id is not also new_reg_id this cycle.
- Normal update, rename (new_reg_id != 0): busy[new_reg_id] <= 1, tag[new_reg_id] <= new_rob_id. Rename wins over a commit clear on the same register in the same cycle.
- Commit with a stale tag (register renamed again since): value written, busy and tag untouched.
- Query path is fully combinational, zero latency. Shown for rs1; rs2 is identical.
  - rob_rs1_id = tag[dec_rs1_addr] when busy, else 0.
  - If addr == 0 or !busy: ready=1, val=val[addr], tag=0.
  - Else, commit bypass: if commit_reg_id == addr and commit_rob_id == tag[addr] and !clear_flag and rdy_in, then ready=1, val=commit_val.
  - Else, ROB forward: if rob_rs1_ready, then ready=1, val=rob_rs1_val.
  - Else: ready=0, val=0, tag=tag[addr].
- Queries see pre-rename state: an instruction renaming rd in the same cycle it reads rd gets the old mapping.
- While clear_flag is high, queries still return the current (pre-flush) state. The decoder discards them.

Test Plan:
1. Reset -> query x5: rs1_ready=1, rs1_val=0, rs1_tag=0.
2. Rename x3 to tag 7. Next cycle query x3 with rob_rs1_ready=0 -> ready=0, tag=7, rob_rs1_id=7. Then drive rob_rs1_ready=1, rob_rs1_val=0x55 -> ready=1, val=0x55.
3. Rename x3 tag 7, then commit x3/tag 7/0xAB -> during the commit cycle the query returns ready=1, 0xAB (bypass). Next cycle busy=0, val=0xAB.
4. Rename x3 tag 7, then rename x3 tag 9. Commit x3/tag 7/0x11 -> val=0x11 but busy stays, tag=9. Commit tag 9/0x22 -> busy=0, val=0x22.
5. Same cycle: commit x4/tag 2 (matching) and rename x4 tag 6 -> val updated, busy=1, tag=6.
6. Renames on x1, x2 pending, then clear_flag=1 with a simultaneous commit x1 -> all busy 0, x1 value unchanged. With rdy_in=0 and commit driven, nothing changes. Rename and commit to x0 -> query x0 gives 0, ready.
